dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single data memory between the pipeline MEM stage (port C) and a DMA/loader master (port D). It sits between the MEM-stage memory request lines and the `d_mem` instance. The MEM stage normally has priority; a saturating starvation counter forces a DMA grant after `STARVE_MAX` consecutive lost cycles, and the pipeline is stalled for that cycle. DMA read data is returned registered, one cycle after the grant.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive DMA losses before forced DMA grant (legal 1..15)

- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `cpu_re`  in  1  MEM-stage MemRead
- `cpu_we`  in  1  MEM-stage MemWrite
- `cpu_addr`  in  ADDR_W  MEM-stage ALU result
- `cpu_wdata`  in  DATA_W  MEM-stage store data
- `cpu_rdata`  out  DATA_W  load data to MEM/WB latch (combinational from memory)
- `cpu_stall`  out  1  hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle
- `dma_req`  in  1  DMA request, held stable until granted
- `dma_we`  in  1  1 = write, 0 = read
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  access performed at this clock edge
- `dma_rdata`  out  DATA_W  registered read data
- `dma_rvalid`  out  1  one-cycle pulse, `dma_rdata` valid
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  to memory
- `mem_we`, `mem_re`  out  1  to memory
- `mem_rdata`  in  DATA_W  from memory (combinational read)
- `starve_cnt`  out  4  current starvation count (debug)

## Operation
- `cpu_req = cpu_re | cpu_we`; `cpu_re & cpu_we` together is illegal, treated as write.
- Grant, combinational each cycle:
  - `force = dma_req & (starve_cnt == STARVE_MAX)`
  - owner = DMA if `force`, else CPU if `cpu_req`, else DMA if `dma_req`, else NONE.
- Memory mux: owner CPU → CPU fields drive `mem_*`; DMA → DMA fields; NONE → `mem_we = mem_re = 0`, address/data = 0.
- `cpu_rdata = mem_rdata` always; valid only when owner = CPU.
- `cpu_stall = cpu_req & (owner == DMA)`; never asserted without `cpu_req`.
- `dma_gnt = (owner == DMA)`.
- Starvation counter, registered:
  - `dma_req & owner == CPU` → increment, saturating at `STARVE_MAX`.
  - `owner == DMA` or `!dma_req` → 0.
- Read return: on an edge with `dma_gnt & !dma_we`, `dma_rdata <= mem_rdata`, `dma_rvalid <= 1`; otherwise `dma_rvalid <= 0`, `dma_rdata` holds.
- DMA may drop `dma_req` only after the `dma_gnt` cycle. Back-to-back DMA grants are allowed when the CPU is idle or forced.

## Timing
- Reset values: `starve_cnt = 0`, `dma_rvalid = 0`, `dma_rdata = 0`. Combinational outputs follow inputs immediately after reset release.
- CPU access is zero-latency: same cycle, as without the arbiter.
- DMA write commits at the edge ending the `dma_gnt` cycle.
- DMA read: `dma_rvalid` is high exactly one cycle after the `dma_gnt` cycle.
- Worst-case DMA wait under continuous CPU traffic: `STARVE_MAX` cycles, granted in cycle `STARVE_MAX+1`. The CPU then stalls for exactly 1 cycle and the counter returns to 0.
- Simultaneous first requests: CPU wins; counter goes to 1.
- Reset asserted mid-read: an in-flight `dma_rvalid` is cleared asynchronously and the data is not delivered. The DMA master must reissue.

## Structure
- Shared package `mem_pkg`: owner enum {OWN_NONE, OWN_CPU, OWN_DMA}, default `ADDR_W`/`DATA_W`.
- Sub-module `starve_counter` (saturating counter with clear and increment, width 4, max parameter) is natural. The rest is a flat mux plus the read-return register.
- `mem_stage` instantiates `dmem_arbiter` ahead of `d_mem`. `cpu_stall` is exported to the hazard unit.

## Test plan
- CPU only: load from 0x10 holding 0xDEADBEEF → `cpu_rdata = 0xDEADBEEF` same cycle; `cpu_stall`, `dma_gnt` and `starve_cnt` stay 0.
- DMA only: write 0xA5A5A5A5 @0x20, then read 0x20 → `dma_gnt` high 1 cycle each; `dma_rvalid` pulses 1 cycle after the read grant with 0xA5A5A5A5.
- Contention with `STARVE_MAX=4`, `cpu_req` and `dma_req` held high → CPU wins cycles 1-4 with `starve_cnt` 1,2,3,4; cycle 5 `dma_gnt=1`, `cpu_stall=1`; cycle 6 CPU wins and `starve_cnt = 1`.
- Stalled CPU store to 0x30 during a forced DMA cycle → memory at 0x30 is unchanged that cycle and written the next cycle. The DMA write lands in its own cycle.
- `dma_req` drops while the counter is at 3 → `starve_cnt` returns to 0 the next cycle.
- `rst_n` low during the `dma_rvalid` cycle → `dma_rvalid` is 0 immediately; `starve_cnt = 0` and `dma_rdata = 0`.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // A forced DMA grant beats the CPU; otherwise the CPU has priority and the
    // DMA master takes the memory whenever the CPU leaves it idle.
    function automatic owner_e pick_owner(input logic force_dma,
                                          input logic cpu_req,
                                          input logic dma_req);
        owner_e own;
        if (force_dma)    own = OWN_DMA;
        else if (cpu_req) own = OWN_CPU;
        else if (dma_req) own = OWN_DMA;
        else              own = OWN_NONE;
        return own;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and memory-side signal bundle for the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // MEM-stage side
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // DMA / loader side
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Debug
    logic [3:0]        starve_cnt;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output starve_cnt
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  starve_cnt
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// rtl/dmem_arbiter_starve_counter.sv - saturating 4-bit DMA starvation counter with clear
module dmem_arbiter_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory between the MEM stage and a DMA master
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    owner_e            owner;
    logic              cpu_req;
    logic              force_dma;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              at_max;
    logic [CNT_W-1:0]  starve_cnt;

    logic [DATA_W-1:0] dma_rdata_q;
    logic              dma_rvalid_q;

    // Ownership decision for this cycle; a starved DMA master is forced in.
    always_comb begin
        cpu_req   = bus.cpu_re | bus.cpu_we;
        force_dma = bus.dma_req & at_max;
        owner     = pick_owner(force_dma, cpu_req, bus.dma_req);
    end

    // Memory port mux; a CPU re+we collision is treated as a store.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (owner)
            OWN_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
                bus.mem_re    = bus.cpu_re & ~bus.cpu_we;
            end
            OWN_DMA: begin
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                bus.mem_we    = bus.dma_we;
                bus.mem_re    = ~bus.dma_we;
            end
            default: ;
        endcase
    end

    // Starvation tracking: count DMA losses, reset on a grant or when DMA is idle.
    always_comb begin
        cnt_clr = ~bus.dma_req | (owner == OWN_DMA);
        cnt_inc = bus.dma_req & (owner == OWN_CPU);
    end

    dmem_arbiter_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .cnt_o    (starve_cnt),
        .at_max_o (at_max)
    );

    // DMA read return: capture memory data on a read grant, pulse valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            dma_rvalid_q <= 1'b0;
            if ((owner == OWN_DMA) && !bus.dma_we) begin
                dma_rdata_q  <= bus.mem_rdata;
                dma_rvalid_q <= 1'b1;
            end
        end
    end

    // Output drive; the CPU only stalls when it actually wanted the memory.
    always_comb begin
        bus.cpu_rdata  = bus.mem_rdata;
        bus.cpu_stall  = cpu_req & (owner == OWN_DMA);
        bus.dma_gnt    = (owner == OWN_DMA);
        bus.dma_rdata  = dma_rdata_q;
        bus.dma_rvalid = dma_rvalid_q;
        bus.starve_cnt = starve_cnt;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (bus.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_starve got %0d exp 0", bus.starve_cnt); end
        n_checks++;
        if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", bus.dma_rvalid); end
        n_checks++;
        if (bus.dma_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.dma_rdata); end
        n_checks++;
        if ({bus.dma_gnt, bus.mem_we, bus.mem_re, bus.cpu_stall} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_idle gnt/we/re/stall got %b exp 0000",
                               {bus.dma_gnt, bus.mem_we, bus.mem_re, bus.cpu_stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_cpu_only();
        mem[8'h10] = 32'hDEADBEEF;
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 32'h10;
        #1;
        n_checks++;
        if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_load got %h exp deadbeef", bus.cpu_rdata); end
        n_checks++;
        if ({bus.cpu_stall, bus.dma_gnt, bus.mem_re} !== 3'b001) begin
            n_fail++; $display("FAIL cpu_load_ctrl stall/gnt/re got %b exp 001", {bus.cpu_stall, bus.dma_gnt, bus.mem_re});
        end
        tick();
        n_checks++;
        if (bus.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL cpu_only_starve got %0d exp 0", bus.starve_cnt); end
        // re and we together behave as a store
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h14;
        bus.cpu_wdata = 32'h01234567;
        #1;
        n_checks++;
        if ({bus.mem_we, bus.mem_re} !== 2'b10) begin n_fail++; $display("FAIL cpu_re_we got we/re %b exp 10", {bus.mem_we, bus.mem_re}); end
        tick();
        n_checks++;
        if (mem[8'h14] !== 32'h01234567) begin n_fail++; $display("FAIL cpu_store got %h exp 01234567", mem[8'h14]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_dma_only();
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h20;
        bus.dma_wdata = 32'hA5A5A5A5;
        #1;
        n_checks++;
        if ({bus.dma_gnt, bus.mem_we, bus.cpu_stall} !== 3'b110) begin
            n_fail++; $display("FAIL dma_wr_gnt gnt/we/stall got %b exp 110", {bus.dma_gnt, bus.mem_we, bus.cpu_stall});
        end
        tick();
        n_checks++;
        if (mem[8'h20] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL dma_write got %h exp a5a5a5a5", mem[8'h20]); end
        n_checks++;
        if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_wr_rvalid got %b exp 0", bus.dma_rvalid); end
        bus.dma_we = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_gnt, bus.mem_re} !== 2'b11) begin n_fail++; $display("FAIL dma_rd_gnt gnt/re got %b exp 11", {bus.dma_gnt, bus.mem_re}); end
        tick();
        bus.dma_req = 1'b0;
        #1;
        n_checks++;
        if (bus.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL dma_gnt_drop got %b exp 0", bus.dma_gnt); end
        n_checks++;
        if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL dma_read got valid %b data %h exp 1 a5a5a5a5", bus.dma_rvalid, bus.dma_rdata);
        end
        tick();
        n_checks++;
        if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL dma_rvalid_pulse got valid %b data %h exp 0 a5a5a5a5", bus.dma_rvalid, bus.dma_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 32'h10;
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 32'h20;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_checks++;
            if ({bus.dma_gnt, bus.cpu_stall} !== 2'b00 || bus.mem_addr !== 32'h10) begin
                n_fail++; $display("FAIL contend_cpu_win cycle %0d gnt/stall %b addr %h exp 00 10", k, {bus.dma_gnt, bus.cpu_stall}, bus.mem_addr);
            end
            tick();
            n_checks++;
            if (bus.starve_cnt !== 4'(k)) begin n_fail++; $display("FAIL contend_starve cycle %0d got %0d exp %0d", k, bus.starve_cnt, k); end
        end
        #1;
        n_checks++;
        if ({bus.dma_gnt, bus.cpu_stall} !== 2'b11 || bus.mem_addr !== 32'h20) begin
            n_fail++; $display("FAIL contend_force gnt/stall %b addr %h exp 11 20", {bus.dma_gnt, bus.cpu_stall}, bus.mem_addr);
        end
        tick();
        n_checks++;
        if (bus.starve_cnt !== 4'd0 || bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL contend_after_force starve %0d valid %b data %h exp 0 1 a5a5a5a5",
                               bus.starve_cnt, bus.dma_rvalid, bus.dma_rdata);
        end
        n_checks++;
        if ({bus.dma_gnt, bus.cpu_stall} !== 2'b00) begin n_fail++; $display("FAIL contend_cycle6 gnt/stall got %b exp 00", {bus.dma_gnt, bus.cpu_stall}); end
        tick();
        n_checks++;
        if (bus.starve_cnt !== 4'd1) begin n_fail++; $display("FAIL contend_cycle6_starve got %0d exp 1", bus.starve_cnt); end
        idle_inputs();
        tick();
    endtask

    task automatic test_stalled_store();
        mem[8'h30] = 32'hCAFE0000;
        mem[8'h40] = 32'h0;
        bus.cpu_re    = 1'b1;
        bus.cpu_addr  = 32'h10;
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h40;
        bus.dma_wdata = 32'h22222222;
        for (int k = 0; k < 4; k++) tick();
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h30;
        bus.cpu_wdata = 32'h11111111;
        #1;
        n_checks++;
        if (bus.cpu_stall !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h22222222) begin
            n_fail++; $display("FAIL store_forced stall %b addr %h data %h exp 1 40 22222222", bus.cpu_stall, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.dma_req = 1'b0;
        n_checks++;
        if (mem[8'h30] !== 32'hCAFE0000 || mem[8'h40] !== 32'h22222222) begin
            n_fail++; $display("FAIL store_stalled mem30 %h mem40 %h exp cafe0000 22222222", mem[8'h30], mem[8'h40]);
        end
        #1;
        n_checks++;
        if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL store_unstall got %b exp 0", bus.cpu_stall); end
        tick();
        n_checks++;
        if (mem[8'h30] !== 32'h11111111) begin n_fail++; $display("FAIL store_retry got %h exp 11111111", mem[8'h30]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_drop_req();
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 32'h10;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h20;
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (bus.starve_cnt !== 4'd3) begin n_fail++; $display("FAIL drop_build got %0d exp 3", bus.starve_cnt); end
        bus.dma_req = 1'b0;
        tick();
        n_checks++;
        if (bus.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL drop_clear got %0d exp 0", bus.starve_cnt); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        mem[8'h50] = 32'h5A5A0F0F;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h50;
        tick();
        bus.dma_req = 1'b0;
        n_checks++;
        if (bus.dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b exp 1", bus.dma_rvalid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0 || bus.starve_cnt !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid valid %b data %h starve %0d exp 0 0 0", bus.dma_rvalid, bus.dma_rdata, bus.starve_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_dma_only();
        test_contention();
        test_stalled_store();
        test_drop_req();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
